// File: rtl/popcount_pipe.sv
//------------------------------------------------------------------------------
// Module      : popcount_pipe
// Description : Pipelined, valid/ready handshaked population counter. Each
//               accepted N-bit word is reduced by a pairwise adder tree. The
//               tree levels are split evenly across STAGES register stages;
//               any stages beyond the tree depth act as pure delay.
//
//               Optional feature, macro POPCOUNT_PIPE_ACCUM_EN:
//                 defined   - the final stage keeps a saturating ACC_W running
//                             total per packet, and out_last marks the end of
//                             the packet (packets are delimited by in_last).
//                 undefined - out_acc and out_last are tied to 0 and in_last
//                             is ignored. Latency and handshake are unchanged.
//
// Ports       : clk, rst      - clock; asynchronous active-high reset
//               in_valid/in_ready/in_data/in_last - input beat
//               out_valid/out_ready               - output handshake
//               out_count     - ones in the beat (COUNT_WIDTH+1 bits)
//               out_acc       - running packet total including this beat
//               out_last      - delayed in_last
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module popcount_pipe #(
   parameter  int N           = 8,
   parameter  int STAGES      = 2,
   parameter  int ACC_W       = 16,
   localparam int COUNT_WIDTH = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COUNT_WIDTH:0]   out_count,
   output logic [ACC_W-1:0]       out_acc,
   output logic                   out_last
);

   localparam int LEVELS = $clog2(N);
   localparam int CW     = COUNT_WIDTH;

   // Partial sums of one tree level. 2*N slots so that pair indexing never
   // runs off the end; slots N..2N-1 are always zero.
   typedef logic [2*N-1:0][CW:0] sums_t;

   // Applies tree levels lo..hi-1 in place. Reading slots 2i and 2i+1 is safe
   // while writing slot i, since for i >= 1 both lie above every slot already
   // rewritten in this level. After all LEVELS, slot 0 holds the total.
   function automatic sums_t f_reduce(input sums_t v, input int lo, input int hi);
      sums_t t;
      t = v;
      for (int l = 0; l < LEVELS; l++) begin
         if (l >= lo && l < hi) begin
            for (int i = 0; i < N; i++) begin
               t[i] = t[2*i] + t[2*i+1];
            end
         end
      end
      return t;
   endfunction

   sums_t               w_in;
   sums_t               w_next [STAGES];
   sums_t               r_sums [STAGES];
   logic [STAGES-1:0]   r_valid;
   logic [STAGES:0]     w_vchain;
   logic                w_adv;
   logic                w_unused_sums;

   always_comb begin
      w_in = '0;
      for (int i = 0; i < N; i++) begin
         w_in[i][0] = in_data[i];
      end
   end

   // Every stage advances together; a bubble occupies its slot like a beat.
   assign w_adv     = out_ready | ~r_valid[STAGES-1];
   assign in_ready  = w_adv;
   assign w_vchain  = {r_valid, in_valid};

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = (s * LEVELS) / STAGES;
      localparam int HI = ((s + 1) * LEVELS) / STAGES;
      if (s == 0) begin : g_first
         assign w_next[s] = f_reduce(w_in, LO, HI);
      end else begin : g_rest
         assign w_next[s] = f_reduce(r_sums[s-1], LO, HI);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_sums[s] <= '0;
         end
      end else if (w_adv) begin
         r_valid <= w_vchain[STAGES-1:0];
         for (int s = 0; s < STAGES; s++) begin
            r_sums[s] <= w_next[s];
         end
      end
   end

   assign out_valid     = r_valid[STAGES-1];
   assign out_count     = r_sums[STAGES-1][0];
   // Only slot 0 of the final stage is an output; the rest is trimmed.
   assign w_unused_sums = ^r_sums[STAGES-1];

`ifdef POPCOUNT_PIPE_ACCUM_EN
   localparam int SW = ((ACC_W > CW + 1) ? ACC_W : CW + 1) + 1;

   logic [STAGES-1:0]   r_last;
   logic [STAGES:0]     w_lchain;
   logic [ACC_W-1:0]    r_acc;
   logic                r_prev_last;
   logic [ACC_W-1:0]    w_acc_base;
   logic [SW-1:0]       w_acc_sum;
   logic [ACC_W-1:0]    w_acc_new;
   logic [CW:0]         w_fin_count;

   // Bubbles carry last=0 so out_last never shows a stale flag.
   assign w_lchain    = {r_last, in_last & in_valid};
   assign w_fin_count = w_next[STAGES-1][0];
   assign w_acc_base  = r_prev_last ? '0 : r_acc;
   assign w_acc_sum   = SW'(w_acc_base) + SW'(w_fin_count);
   // Once saturated, adding any count overflows again, so the total stays
   // pinned until a beat with last closes the packet.
   assign w_acc_new   = (|w_acc_sum[SW-1:ACC_W]) ? '1 : w_acc_sum[ACC_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last      <= '0;
         r_acc       <= '0;
         r_prev_last <= 1'b1;
      end else if (w_adv) begin
         r_last <= w_lchain[STAGES-1:0];
         if (w_vchain[STAGES-1]) begin
            r_acc       <= w_acc_new;
            r_prev_last <= w_lchain[STAGES-1];
         end
      end
   end

   assign out_acc  = r_acc;
   assign out_last = r_last[STAGES-1];
`else
   logic w_unused_in_last;

   assign w_unused_in_last = in_last;
   assign out_acc          = '0;
   assign out_last         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/popcount_pipe.md
# popcount_pipe

Pipelined, handshaked population counter: the parametrised successor to the combinational ones-counter. It accepts an N-bit word per cycle and returns its ones count after a fixed, parameterised register latency. An optional accumulation mode keeps a running total across a multi-beat packet delimited by `in_last`. It sits between the sample/coefficient datapath and the FIR control/statistics logic, where sparse-coefficient and bit-density metrics are needed at full clock rate.

## Interface

Parameters:
- `N`, 8: input word width; N ≥ 1.
- `STAGES`, 2: register stages from input to output, STAGES ≥ 1.
- `ACC_W`, 16: accumulator width; only meaningful with the accumulate feature.
- Derived `COUNT_WIDTH` = $clog2(N); count output is COUNT_WIDTH+1 bits wide.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts beat this cycle.
- `in_data`  in  N  word to count.
- `in_last`  in  1  final beat of packet (accumulate mode only).
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  consumer accepts beat.
- `out_count`  out  COUNT_WIDTH+1  ones in the corresponding `in_data`.
- `out_acc`  out  ACC_W  running packet total including this beat.
- `out_last`  out  1  delayed copy of `in_last`.

## Operation

- Global advance enable `adv = out_ready | ~out_valid`; `in_ready = adv` (combinational).
- Beat accepted when `in_valid & in_ready`. All STAGES registers shift together on `adv`; each stage carries a valid bit. Bubbles are not compressed.
- Count is an adder tree over the N bits. Pipeline registers are spread evenly across tree levels; stages beyond the tree depth are pure delay.
- Count is exact for all N: all-ones yields N, so N=16 returns 5'd16.
- Output held stable (data and valid) while `out_valid & ~out_ready`.
- Beat order is preserved; no beat is dropped or duplicated.
- Reset values: every stage valid = 0, `out_valid` 0, `out_count` 0, `out_acc` 0, `out_last` 0. `in_ready` is 1 immediately after reset.
- `rst` asserted mid-operation discards all in-flight beats and clears the accumulator. No output appears after release until new beats are accepted.

## Timing

- Latency: a beat accepted at edge k appears on `out_valid` after edge k+STAGES, provided `adv` stays high.
- Throughput: one beat per cycle with `out_ready` held high.
- A stall of S cycles adds exactly S cycles to every in-flight beat.
- Reset assertion clears outputs asynchronously, without waiting for `clk`. Deassertion is synchronised by the integrator.

## Configuration

- Macro `POPCOUNT_PIPE_ACCUM_EN`.
- Defined:
  - The final stage holds an ACC_W accumulator and a "previous beat was last" flag (reset 1).
  - On each valid beat advancing into the final stage: `acc = (prev_last ? 0 : acc) + count`, then `prev_last = last`.
  - The addition saturates at 2^ACC_W−1 and stays saturated until the packet ends.
  - `out_acc` shows the updated value; `out_last` mirrors the beat's `in_last`.
- Undefined:
  - No accumulator is built.
  - `out_acc` is tied to 0, `out_last` is tied to 0, and `in_last` is ignored.
  - Latency and handshake are identical to the defined case.

## Test plan

- N=8, STAGES=2, `out_ready`=1: inputs 8'hFF, 8'h00, 8'hA5 on consecutive cycles → `out_count` 8, 0, 4 on consecutive cycles, first one 2 cycles after acceptance.
- Backpressure: fill pipe, drop `out_ready` for 5 cycles → `out_valid` and `out_count` stable, `in_ready` 0 throughout, no loss or reorder after release.
- Accumulate (macro on): 8'h0F, 8'hF0, 8'hFF with last on the third → `out_acc` 4, 8, 16, `out_last` 0, 0, 1. Next beat 8'h01 → `out_acc` 1.
- Saturation (macro on, ACC_W=4): 8'hFF, 8'hFF, 8'h01 in one packet → `out_acc` 8, 15, 15.
- Reset mid-stream: 2 beats in flight, pulse `rst` between edges → `out_valid` drops immediately, no spurious output after release, first new packet's `out_acc` starts from its own count.
- Width corners: N=1 with inputs 1, 0 → counts 1, 0. N=16 with 16'hFFFF → `out_count` 5'd16. STAGES=1 → latency 1.
